// File: rtl/shift_pkg.sv
// Shared types and default sizing for the multi-cycle right shifter.
package shift_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SHW   = 5;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/right_shift_unit.sv
// Multi-cycle logical/arithmetic right shifter, one bit per clock, start/done handshake.
module right_shift_unit
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = shift_pkg::WIDTH,
    parameter int unsigned SHW   = shift_pkg::SHW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic [SHW-1:0]   i_shamt,
    input  logic             i_arith,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_lost
);

    state_e           r_state;
    logic [SHW-1:0]   r_count;
    logic             r_fill;
    logic [WIDTH-1:0] r_result;
    logic             r_lost;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_count  <= '0;
            r_fill   <= 1'b0;
            r_result <= '0;
            r_lost   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_result <= i_data_in;
                        r_count  <= i_shamt;
                        r_fill   <= i_arith & i_data_in[WIDTH-1];
                        r_lost   <= 1'b0;
                        r_state  <= (i_shamt != '0) ? StShift : StDone;
                    end
                end
                StShift: begin
                    r_result <= {r_fill, r_result[WIDTH-1:1]};
                    r_lost   <= r_lost | r_result[0];
                    r_count  <= r_count - 1'b1;
                    if (r_count == SHW'(1)) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Handshake flags are pure state decodes so inputs never reach them combinationally.
    assign o_ready  = (r_state == StIdle);
    assign o_busy   = (r_state == StShift);
    assign o_done   = (r_state == StDone);
    assign o_result = r_result;
    assign o_lost   = r_lost;

endmodule

// File: doc/right_shift_unit.md
# right_shift_unit

Multi-cycle right shifter that performs logical (zero-fill) or arithmetic (sign-fill) right shifts one bit position per clock. It is the opposite-direction counterpart of the datapath's left-shift and sign-extension helpers. It executes SRL/SRA-class operations for the processor datapath through a start/done handshake. Operands are captured once at accept, so the datapath may change its inputs while a shift is in progress.

## Interface
- WIDTH, 32: operand and result width.
- SHW, 5: shift-amount width; must equal log2(WIDTH).

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when ready=1.
- data_in  in  WIDTH  operand; captured at accept.
- shamt  in  SHW  shift amount, 0..WIDTH-1; captured at accept.
- arith  in  1  1 = arithmetic (fill with data_in[WIDTH-1]), 0 = logical (fill 0); captured at accept.
- ready  out  1  high only in IDLE; reset 1.
- busy  out  1  high only in SHIFT; reset 0.
- done  out  1  one-cycle pulse, high only in DONE; reset 0.
- result  out  WIDTH  shifted value; reset 0; holds until the next accept.
- lost  out  1  OR of every bit shifted out of bit 0; reset 0; updated with result.

## Operation
- States: IDLE, SHIFT, DONE.
- Accept: a clock edge with state=IDLE and start=1.
  - At accept: result <= data_in; count <= shamt; fill <= arith & data_in[WIDTH-1]; lost <= 0.
  - Next state: SHIFT if shamt != 0, otherwise DONE.
- SHIFT, on each edge:
  - result <= {fill, result[WIDTH-1:1]}; lost <= lost | result[0]; count <= count-1.
  - When count=1 on that edge, next state is DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start is ignored outside IDLE, including DONE; it is neither queued nor counted.
- data_in, shamt and arith are don't-care except at the accept edge.
- The fill bit is latched once, so an arithmetic shift of a negative operand fills with ones for every shift step.
- result equals data_in >> shamt (logical) or >>> shamt (arithmetic), with full WIDTH-bit precision. No bits are lost except those reported via lost.
- Reset, asserted at any time (including mid-SHIFT):
  - Immediately forces IDLE, result=0, lost=0 and count=0.
  - No done pulse is produced for the aborted operation.
  - After rst_n deasserts, the first rising edge may accept.

## Timing
- Accept at edge E0. With N = captured shamt, the shifts occur at edges E1..EN, and done is high during cycle N+1 after E0.
- Latency is N+1 cycles. Examples: shamt=0 gives 1 cycle; shamt=31 gives 32 cycles.
- result and lost are final, and stable, when done is high; they stay stable through IDLE.
- Back-to-back operations: the next accept happens at the earliest one cycle after done (the IDLE cycle). Peak throughput is one operation per N+2 cycles.
- ready, busy and done are decoded from state only, with no combinational path from inputs.
- Exactly one of ready, busy and done is high in every cycle.

## Structure
- Shared package shift_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - default constants WIDTH=32 and SHW=5.
- Single module with no sub-modules. Registers: state, count[SHW-1:0], fill, result, lost.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release -> ready=1, busy=0, done=0, result=0x0000_0000, lost=0.
- Logical shift: data_in=0x8000_00F0, shamt=4, arith=0 -> done in cycle 5 after accept; result=0x0800_000F, lost=0.
- Arithmetic shift with lost bit: data_in=0x8000_00F0, shamt=5, arith=1 -> done in cycle 6; result=0xFC00_0007, lost=1.
- Zero shift: data_in=0x1234_5678, shamt=0 -> done in cycle 1; result=0x1234_5678, lost=0.
- Maximum shift, start while busy:
  - Operation: data_in=0x8000_0000, shamt=31, arith=1.
  - In cycle 3, drive start=1, data_in=0x0000_0001, shamt=1 (this request must be ignored).
  - Required: single done in cycle 32, result=0xFFFF_FFFF, lost=0. The bench then holds start=1 continuously from cycle 32: no new operation is accepted in the done cycle; the request is accepted at the edge ending cycle 33, so ready=1 in cycle 33 and busy=1 in cycle 34.
- Reset mid-operation: data_in=0xFFFF_0000, shamt=20, logical; pull rst_n low in cycle 3 -> in the same cycle ready=1, result=0, lost=0; after release no done pulse appears. A new shamt=1 request then completes normally, with done in cycle 2 after its accept.
